// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test controller.
// The MISR constants are consumed only when SCAN_CTRL_MISR_EN is defined.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // One MISR step: shift left, fold the dropped MSB back through the
    // polynomial taps, and XOR the new response bit into bit 0.
    function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic din);
        logic [15:0] fb;
        fb = sig[15] ? MISR_POLY : 16'h0000;
        return {sig[14:0], 1'b0} ^ fb ^ {15'h0000, din};
    endfunction

endpackage

// File: rtl/scan_misr.sv
// 16-bit multiple-input signature register over the scan response stream.
// Only present in builds with SCAN_CTRL_MISR_EN defined.
`ifdef SCAN_CTRL_MISR_EN
module scan_misr
    import scan_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] sig_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_reg <= 16'h0000;
        end else if (clr) begin
            sig_reg <= MISR_SEED;
        end else if (en) begin
            sig_reg <= misr_next(sig_reg, scan_din_fix(din));
        end
    end

    function automatic logic scan_din_fix(input logic d);
        return d;
    endfunction

    assign sig = sig_reg;

endmodule
`endif

// File: rtl/scan_ctrl.sv
// Scan test controller: shifts patterns into a chain, captures, compares the
// unloaded response. Optional response MISR enabled by SCAN_CTRL_MISR_EN.
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter  int MAX_LEN = 1024,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] chain_len,
    input  logic [7:0]       n_patterns,
    input  logic             pat_valid,
    input  logic             pat_bit,
    input  logic             exp_bit,
    input  logic             exp_mask,
    output logic             pat_ready,
    output logic             scan_en,
    output logic             scan_in0,
    output logic             scan_clk_en,
    input  logic             scan_out0,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [7:0]       fail_count,
    output logic [15:0]      signature
);

    state_t           state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] bit_cnt_reg;
    logic [7:0]       npat_reg;
    logic [7:0]       pat_cnt_reg;
    logic [7:0]       fail_cnt_reg;
    logic             scan_en_reg;
    logic             pat_ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             fail_reg;

    logic in_shift;
    logic in_unload;
    logic beat;
    logic cmp_en;
    logic mismatch;
    logic last_bit;

    assign in_shift  = (state_reg == ST_SHIFT);
    assign in_unload = (state_reg == ST_UNLOAD);
    assign beat      = pat_ready_reg & pat_valid;
    assign last_bit  = (bit_cnt_reg == (len_reg - LEN_W'(1)));

    // The first pattern's shift unloads whatever the chain held before the
    // run, so only later shifts and the final unload are compared.
    assign cmp_en   = beat & (in_unload | (in_shift & (pat_cnt_reg != 8'd0)));
    assign mismatch = cmp_en & exp_mask & (scan_out0 ^ exp_bit);

    assign scan_clk_en = beat | (state_reg == ST_CAPTURE);
    assign scan_in0    = beat & in_shift & pat_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            bit_cnt_reg   <= '0;
            npat_reg      <= 8'd0;
            pat_cnt_reg   <= 8'd0;
            fail_cnt_reg  <= 8'd0;
            scan_en_reg   <= 1'b0;
            pat_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        len_reg      <= chain_len;
                        npat_reg     <= n_patterns;
                        pat_cnt_reg  <= 8'd0;
                        bit_cnt_reg  <= '0;
                        fail_cnt_reg <= 8'd0;
                        fail_reg     <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (chain_len == '0 || n_patterns == 8'd0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= ST_SHIFT;
                            scan_en_reg   <= 1'b1;
                            pat_ready_reg <= 1'b1;
                        end
                    end
                end
                ST_SHIFT, ST_UNLOAD: begin
                    if (beat) begin
                        if (mismatch) begin
                            fail_reg <= 1'b1;
                            if (fail_cnt_reg != 8'hFF) begin
                                fail_cnt_reg <= fail_cnt_reg + 8'd1;
                            end
                        end
                        if (last_bit) begin
                            bit_cnt_reg   <= '0;
                            scan_en_reg   <= 1'b0;
                            pat_ready_reg <= 1'b0;
                            if (in_shift) begin
                                state_reg   <= ST_CAPTURE;
                                pat_cnt_reg <= pat_cnt_reg + 8'd1;
                            end else begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + LEN_W'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    state_reg     <= (pat_cnt_reg == npat_reg) ? ST_UNLOAD : ST_SHIFT;
                    scan_en_reg   <= 1'b1;
                    pat_ready_reg <= 1'b1;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign scan_en    = scan_en_reg;
    assign pat_ready  = pat_ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign fail       = fail_reg;
    assign fail_count = fail_cnt_reg;

`ifdef SCAN_CTRL_MISR_EN
    scan_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_reg == ST_IDLE) & start),
        .en    (cmp_en),
        .din   (scan_out0),
        .sig   (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: loopback chain model, per-cycle trace
// model built from pattern counts/lengths, plus literal latency/count checks.
module tb_scan_ctrl;

    localparam int MAX_LEN = 1024;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int MAXB    = 1024;
    localparam int MAXT    = 2048;

    logic          clk = 1'b0;
    logic          reset, start, pat_valid, pat_bit, exp_bit, exp_mask;
    logic [LW-1:0] chain_len;
    logic [7:0]    n_patterns;
    logic          pat_ready, scan_en, scan_in0, scan_clk_en, scan_out0;
    logic          busy, done, fail;
    logic [7:0]    fail_count;
    logic [15:0]   signature;

    always #5 clk = ~clk;

    scan_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .chain_len(chain_len),
        .n_patterns(n_patterns), .pat_valid(pat_valid), .pat_bit(pat_bit),
        .exp_bit(exp_bit), .exp_mask(exp_mask), .pat_ready(pat_ready),
        .scan_en(scan_en), .scan_in0(scan_in0), .scan_clk_en(scan_clk_en),
        .scan_out0(scan_out0), .busy(busy), .done(done), .fail(fail),
        .fail_count(fail_count), .signature(signature)
    );

    // Chain under test: plain shift register, holds its value during capture.
    logic [511:0] chain = {16{32'hA5C3_96E1}};
    int           cl = 4;
    bit           zero_chain = 1'b0;
    always @(posedge clk) if (scan_en && scan_clk_en) chain <= {chain[510:0], scan_in0};
    always_comb scan_out0 = (zero_chain || cl == 0) ? 1'b0 : chain[cl-1];

    // Model state
    logic        pb [0:MAXB-1];
    logic        eb [0:MAXB-1];
    logic        mb [0:MAXB-1];
    logic [5:0]  exp_tr  [0:MAXT-1];   // {scan_en,pat_ready,scan_clk_en,busy,done,sin_care}
    logic        exp_sin [0:MAXT-1];
    int          exp_n, g_total, g_stall_at, g_stall_len;
    logic        exp_fail;
    logic [7:0]  exp_fcnt;
    logic [15:0] exp_sig;

    int checks = 0, errors = 0;
    int cur_cyc = 0;
    bit chk_on = 1'b0;
    int done_at = -1;
    logic [4:0] obs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x, add din, reduce.
    function automatic logic [15:0] sig_model(input logic [15:0] s, input logic d);
        logic [16:0] t;
        t = {s, 1'b0} ^ {16'h0, d};
        if (t[16]) t = t ^ 17'h1_1021;
        return t[15:0];
    endfunction

    task automatic add_tr(input logic [4:0] ctl, input logic care, input logic sin);
        exp_tr[exp_n]  = {ctl, care};
        exp_sin[exp_n] = sin;
        exp_n++;
    endtask

    task automatic build(input int n, input int l, input int flip_a, input int flip_b,
                         input int nomask, input bit flip_all, input int stall_at,
                         input int stall_len);
        int  p, j;
        bit  sh, cmp;
        logic ob;
        g_total     = (n == 0 || l == 0) ? 0 : n * l + l;
        g_stall_at  = stall_at;
        g_stall_len = stall_len;
        exp_n    = 0;
        exp_fail = 1'b0;
        exp_fcnt = 8'd0;
`ifdef SCAN_CTRL_MISR_EN
        exp_sig = 16'hFFFF;
`else
        exp_sig = 16'h0000;
`endif
        for (int b = 0; b < g_total; b++) begin
            sh = (b < n * l);
            p  = sh ? b / l : n;
            j  = sh ? b % l : b - n * l;
            pb[b] = 1'($urandom());
            cmp = !(sh && p == 0);
            if (zero_chain || !cmp) ob = 1'b0;
            else                    ob = pb[(p - 1) * l + j];
            eb[b] = ob;
            mb[b] = 1'b1;
            if (b == flip_a || b == flip_b || (flip_all && !sh)) eb[b] = ~ob;
            if (b == nomask) begin eb[b] = ~ob; mb[b] = 1'b0; end
            if (cmp && mb[b] && (eb[b] != ob)) begin
                exp_fail = 1'b1;
                if (exp_fcnt != 8'd255) exp_fcnt++;
            end
`ifdef SCAN_CTRL_MISR_EN
            if (cmp) exp_sig = sig_model(exp_sig, ob);
`endif
            if (b == stall_at)
                for (int s = 0; s < stall_len; s++) add_tr(5'b11010, 1'b0, 1'b0);
            add_tr(5'b11110, 1'b1, sh ? pb[b] : 1'b0);
            if (sh && j == l - 1) add_tr(5'b00110, 1'b0, 1'b0);
        end
        add_tr(5'b00011, 1'b0, 1'b0);
    endtask

    // Single compare process against the model trace.
    always @(negedge clk) begin
        if (!chk_on) begin
            done_at = -1;
        end else begin
            obs = {scan_en, pat_ready, scan_clk_en, busy, done};
            if (cur_cyc < exp_n) begin
                chk($sformatf("ctl@%0d", cur_cyc), 32'(obs), 32'(exp_tr[cur_cyc][5:1]));
                if (exp_tr[cur_cyc][0])
                    chk($sformatf("scan_in0@%0d", cur_cyc), 32'(scan_in0), 32'(exp_sin[cur_cyc]));
            end else begin
                chk($sformatf("idle@%0d", cur_cyc), 32'(obs), 32'(0));
            end
            if (cur_cyc >= exp_n - 1) begin
                chk("fail", 32'(fail), 32'(exp_fail));
                chk("fail_count", 32'(fail_count), 32'(exp_fcnt));
                chk("signature", 32'(signature), 32'(exp_sig));
            end
            if (done && done_at < 0) done_at = cur_cyc;
        end
    end

    int  idx, stall_left;
    bit  took;

    task automatic drive_beat();
        if (idx < g_total && pat_ready && idx == g_stall_at && stall_left > 0) begin
            pat_valid = 1'b0;
            stall_left--;
        end else if (idx < g_total) begin
            pat_valid = 1'b1;
            pat_bit   = pb[idx];
            exp_bit   = eb[idx];
            exp_mask  = mb[idx];
        end else begin
            pat_valid = 1'b0;
        end
    endtask

    task automatic run(input int n, input int l, input int abort_at, input int busy_start_at);
        @(posedge clk); #1;
        chain_len  = LW'(l);
        n_patterns = 8'(n);
        start      = 1'b1;
        pat_valid  = 1'b0;
        idx        = 0;
        stall_left = g_stall_len;
        chk_on     = 1'b0;
        @(posedge clk); #1;
        start      = 1'b0;
        chain_len  = '0;
        n_patterns = 8'd0;
        cur_cyc    = 0;
        chk_on     = 1'b1;
        drive_beat();
        while (cur_cyc < exp_n + 1) begin
            @(negedge clk);
            took = pat_valid && pat_ready;
            @(posedge clk); #1;
            if (took) idx++;
            cur_cyc++;
            start      = (cur_cyc == busy_start_at);
            chain_len  = start ? LW'(3) : '0;
            n_patterns = start ? 8'd5 : 8'd0;
            if (cur_cyc == abort_at) reset = 1'b1;
            if (cur_cyc == abort_at + 1) begin
                chk_on    = 1'b0;
                reset     = 1'b0;
                pat_valid = 1'b0;
                @(negedge clk);
                chk("abort_outs", 32'({scan_en, scan_in0, scan_clk_en, pat_ready, busy, done, fail}), 32'(0));
                chk("abort_fcnt", 32'(fail_count), 32'(0));
                chk("abort_sig", 32'(signature), 32'(0));
                return;
            end
            drive_beat();
        end
        chk_on    = 1'b0;
        pat_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; pat_valid = 1'b0; pat_bit = 1'b0;
        exp_bit = 1'b0; exp_mask = 1'b0; chain_len = '0; n_patterns = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'({scan_en, scan_in0, scan_clk_en, pat_ready, busy, done, fail}), 32'(0));
        chk("reset_fcnt", 32'(fail_count), 32'(0));
        chk("reset_sig", 32'(signature), 32'(0));
        reset = 1'b0;

        // Loopback N=2 L=4, clean, with a start pulse mid-run that must be ignored
        cl = 4;
        build(2, 4, -1, -1, -1, 1'b0, -1, 0);
        run(2, 4, -1, 6);
        chk("lat_n2_l4", 32'(done_at), 32'(14));
        chk("clean_fcnt", 32'(fail_count), 32'(0));
        $display("txn loopback_clean done_at=%0d fail=%0d fcnt=%0d", done_at, fail, fail_count);

        // One expected bit flipped in UNLOAD, one masked flip in SHIFT
        build(2, 4, 9, -1, 5, 1'b0, -1, 0);
        run(2, 4, -1, -1);
        chk("flip_fail", 32'(fail), 32'(1));
        chk("flip_fcnt", 32'(fail_count), 32'(1));
        $display("txn loopback_flip done_at=%0d fail=%0d fcnt=%0d", done_at, fail, fail_count);

        // Three-cycle stall mid-SHIFT; fail from previous run must clear
        build(2, 4, -1, -1, -1, 1'b0, 2, 3);
        run(2, 4, -1, -1);
        chk("lat_stall", 32'(done_at), 32'(17));
        chk("stall_fail", 32'(fail), 32'(0));
        $display("txn stall done_at=%0d fail=%0d", done_at, fail);

        // n_patterns=0 and chain_len=0 go straight to DONE
        build(0, 4, -1, -1, -1, 1'b0, -1, 0);
        run(0, 4, -1, -1);
        chk("lat_n0", 32'(done_at), 32'(0));
        $display("txn n_patterns_zero done_at=%0d fail=%0d", done_at, fail);
        build(3, 0, -1, -1, -1, 1'b0, -1, 0);
        run(3, 0, -1, -1);
        chk("lat_l0", 32'(done_at), 32'(0));
        $display("txn chain_len_zero done_at=%0d", done_at);

        // Reset mid-SHIFT, then a clean run; a flip in pattern 0 is not compared
        build(2, 4, -1, -1, -1, 1'b0, -1, 0);
        run(2, 4, 2, -1);
        $display("txn abort busy=%0d scan_en=%0d", busy, scan_en);
        cl = 5;
        build(3, 5, 1, -1, -1, 1'b0, -1, 0);
        run(3, 5, -1, -1);
        chk("lat_n3_l5", 32'(done_at), 32'(23));
        chk("p0_nocmp_fcnt", 32'(fail_count), 32'(0));
        $display("txn after_abort done_at=%0d fail=%0d fcnt=%0d", done_at, fail, fail_count);

        // fail_count saturation: 300 mismatching unload bits
        cl = 300;
        build(1, 300, -1, -1, -1, 1'b1, -1, 0);
        run(1, 300, -1, -1);
        chk("sat_fcnt", 32'(fail_count), 32'(255));
        $display("txn saturate fail=%0d fcnt=%0d", fail, fail_count);

        // All-zero chain, N=1 L=16: signature is the seed times x^16
        cl = 16;
        zero_chain = 1'b1;
        build(1, 16, -1, -1, -1, 1'b0, -1, 0);
        run(1, 16, -1, -1);
`ifdef SCAN_CTRL_MISR_EN
        chk("misr_zero16", 32'(signature), 32'(16'h1D0F));
`else
        chk("sig_tied", 32'(signature), 32'(16'h0000));
`endif
        zero_chain = 1'b0;
        $display("txn misr_zero sig=%04h", signature);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 1024, meaning the maximum scan chain length in flops.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide port start, input, 1 bit: single-cycle pulse that launches a test run.
REQ-005 SHALL provide port chain_len, input, clog2(MAX_LEN+1) bits: chain length; sampled on start.
REQ-006 SHALL provide port n_patterns, input, 8 bits: pattern count; sampled on start.
REQ-007 SHALL provide ports pat_valid (input, 1), pat_bit (input, 1), exp_bit (input, 1), exp_mask (input, 1), pat_ready (output, 1): stimulus/expect stream, one beat per shift cycle.
REQ-008 SHALL provide ports scan_en (output, 1), scan_in0 (output, 1), scan_clk_en (output, 1) and scan_out0 (input, 1): drive side toward the chain under test.
REQ-009 SHALL provide outputs busy (1), done (1), fail (1) and fail_count (8 bits).
REQ-010 SHALL provide output signature, 16 bits.

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT, CAPTURE, UNLOAD and DONE.
REQ-012 IDLE: on start with chain_len>0 and n_patterns>0 -> SHIFT; pattern counter=0, bit counter=0, fail_count cleared.
REQ-013 start with chain_len==0 or n_patterns==0 SHALL go straight to DONE; fail=0.
REQ-014 start while busy SHALL be ignored.
REQ-015 SHIFT: scan_en=1, pat_ready=1; a beat is consumed when pat_valid&pat_ready, then scan_in0=pat_bit and scan_clk_en=1 on that cycle.
REQ-016 SHIFT stall (pat_valid=0): scan_en stays 1, scan_clk_en=0, counters hold, no compare.
REQ-017 On each consumed beat, scan_out0 SHALL be sampled at that rising edge; the sample is the pre-shift chain tail.
REQ-018 Compare: mismatch = exp_mask & (scan_out0 ^ exp_bit); compare SHALL be disabled for pattern 0, because that unload carries reset contents.
REQ-019 After chain_len beats -> CAPTURE for exactly one cycle: scan_en=0, scan_clk_en=1, pat_ready=0.
REQ-020 CAPTURE -> SHIFT if more patterns remain, else -> UNLOAD.
REQ-021 UNLOAD: like SHIFT, but scan_in0 is forced 0 and pat_bit is ignored; exp_bit/exp_mask are still used; after chain_len beats -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, then -> IDLE; busy=1 in every state except IDLE.
REQ-023 fail SHALL be sticky from the first mismatch until the next accepted start or reset.
REQ-024 fail_count SHALL count mismatching bits, saturating at 255.
REQ-025 Total latency for N patterns and length L with no stalls SHALL be N*(L+1)+L cycles from start to done.

Reset
REQ-026 On reset the block SHALL enter IDLE.
REQ-027 On reset scan_en, scan_in0, scan_clk_en, pat_ready, busy, done, fail, fail_count and signature SHALL all be 0.
REQ-028 Reset mid-run SHALL abort immediately, with no final capture or unload.

Configuration
REQ-029 With macro SCAN_CTRL_MISR_EN defined: signature SHALL be a 16-bit MISR with polynomial x^16+x^12+x^5+1.
REQ-030 With SCAN_CTRL_MISR_EN defined: the MISR SHALL be seeded to 16'hFFFF on start and SHALL shift in scan_out0 on every compare-enabled beat, regardless of mask.
REQ-031 Without SCAN_CTRL_MISR_EN: signature SHALL be tied to 0 and no MISR logic SHALL exist.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the MISR polynomial constant 16'h1021 and the MISR seed constant.
REQ-033 The MISR SHALL be a sub-module scan_misr (clk, reset, clr, en, din, sig), instantiated only under SCAN_CTRL_MISR_EN.

Verification
REQ-034 Loopback (scan_out0 = scan_in0 delayed by L=4 flops), N=2, exp = previous pattern, mask all 1 -> done after 14 cycles, fail=0, fail_count=0.
REQ-035 Same setup with one exp_bit flipped in the UNLOAD phase -> fail=1, fail_count=1.
REQ-036 pat_valid low for 3 cycles mid-SHIFT -> scan_en stays 1, scan_clk_en=0 for 3 cycles, done delayed exactly 3 cycles.
REQ-037 start with n_patterns=0 -> done next cycle, fail=0, scan_en never asserted.
REQ-038 reset asserted mid-SHIFT -> next cycle all outputs 0, state IDLE; a new start runs cleanly.
REQ-039 With SCAN_CTRL_MISR_EN and an all-zero chain, N=1, L=16 -> signature equals the reference-model value of 16 zero bits shifted into seed 16'hFFFF.
